// File: rtl/isa_pkg.sv
// isa_pkg: opcode constants, opcode field layout and sequencer state encoding.
// This package is shared by the sequencer and by every execution FSM.
package isa_pkg;

    // The opcode sits in the top OPC_W bits of every instruction word.
    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'b0101;
    localparam logic [OPC_W-1:0] OP_HALT = 4'b1111;

    // Sequencer state encoding.
    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: clearable up-counter that flags the TIMEOUT-th enabled cycle.
// expired is combinational so the owner can leave its wait state on the same edge.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned    CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles; clear restarts the window.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Asserted during the TIMEOUT-th consecutive enabled cycle.
    assign expired = en && (r_count == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/dispatch controller for the execution FSMs.
// Owns the program counter, reads a synchronous program memory and presents one
// instruction at a time, forcing an all-zero instruction between dispatches.
// Optional single-step gate: define SEQ_STEP_EN to add the `step` input.
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
`ifdef SEQ_STEP_EN
    input  logic               step,
`endif
    output logic [PC_W-1:0]    pmem_addr,
    input  logic [INSTR_W-1:0] pmem_data,
    output logic [INSTR_W-1:0] instruction,
    input  logic               pcInc,
    input  logic               done,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               fault
);

    logic [2:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic               r_inc_seen;

    logic [2:0]         w_state_nxt;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [INSTR_W-1:0] w_ir_nxt;
    logic               w_inc_seen_nxt;
    logic               w_fetch_ok;
    logic               w_expired;
    logic               w_in_exec;

    assign w_in_exec = (r_state == ST_EXEC);

`ifdef SEQ_STEP_EN
    logic r_step_used;

    // A step pulse launches one fetch; step must drop low before it can launch another.
    always_ff @(posedge clk) begin
        if (rst || !step) begin
            r_step_used <= 1'b0;
        end else if (r_state == ST_FETCH && run) begin
            r_step_used <= 1'b1;
        end
    end

    assign w_fetch_ok = run && step && !r_step_used;
`else
    assign w_fetch_ok = run;
`endif

    // Watchdog runs only in EXEC and restarts from zero on every dispatch.
    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!w_in_exec),
        .en      (w_in_exec),
        .expired (w_expired)
    );

    // Next-state, pc and instruction-register update.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_inc_seen_nxt = r_inc_seen;
        case (r_state)
            ST_FETCH: begin
                if (w_fetch_ok) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ir_nxt       = pmem_data;
                w_inc_seen_nxt = 1'b0;
                case (pmem_data[INSTR_W-1 -: OPC_W])
                    OP_NOP: begin
                        w_pc_nxt    = r_pc + 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                    OP_HALT: w_state_nxt = ST_HALT;
                    default: w_state_nxt = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                // First of pcInc/done advances pc; anything after it is ignored.
                if ((pcInc || done) && !r_inc_seen) begin
                    w_pc_nxt = r_pc + 1'b1;
                end
                if (pcInc) begin
                    w_inc_seen_nxt = 1'b1;
                end
                if (done) begin
                    w_state_nxt    = ST_FETCH;
                    w_inc_seen_nxt = 1'b0;
                end else if (w_expired) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_HALT, ST_FAULT: begin
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_pc       <= '0;
            r_ir       <= '0;
            r_inc_seen <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_inc_seen <= w_inc_seen_nxt;
        end
    end

    assign pmem_addr   = r_pc;
    assign pc          = r_pc;
    assign instruction = w_in_exec ? r_ir : '0;
    assign halted      = (r_state == ST_HALT);
    assign fault       = (r_state == ST_FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized and directed checks of instr_sequencer against a
// timeline model computed from the program and the execution-FSM response schedule.
module tb_instr_sequencer;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int TIMEOUT = 15;
    localparam int MAXC    = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  pmem_addr;
    logic [15:0] pmem_data;
    logic [15:0] instruction;
    logic        pcInc;
    logic        done;
    logic [7:0]  pc;
    logic        halted;
    logic        fault;

    int checks = 0;
    int errors = 0;

    logic [15:0] prog [256];
    int          pinc_off [64];  // EXEC cycle of pcInc per dispatch, -1 = none
    int          done_off [64];  // EXEC cycle of done per dispatch, -1 = never
    bit          noise_en = 1'b0;

    logic [15:0] rec_instr [MAXC];
    logic [7:0]  rec_pc    [MAXC];
    logic [7:0]  rec_addr  [MAXC];
    logic        rec_halt  [MAXC];
    logic        rec_fault [MAXC];

    logic [15:0] exp_instr [MAXC];
    logic [7:0]  exp_pc    [MAXC];
    logic        exp_halt  [MAXC];
    logic        exp_fault [MAXC];

    always #5 clk = ~clk;

    // Synchronous program memory.
    always @(posedge clk) pmem_data <= prog[pmem_addr];

    instr_sequencer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .pmem_addr   (pmem_addr),
        .pmem_data   (pmem_data),
        .instruction (instruction),
        .pcInc       (pcInc),
        .done        (done),
        .pc          (pc),
        .halted      (halted),
        .fault       (fault)
    );

    // Execution-FSM stand-in: responds per dispatch, optional junk outside EXEC.
    initial begin : exec_model
        int cyc;
        int didx;
        int n_disp;
        bit in_exec;
        cyc = 0; didx = 0; n_disp = 0; in_exec = 1'b0;
        pcInc = 1'b0;
        done  = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) n_disp = 0;
            #1;
            if (instruction != 16'h0000) begin
                if (!in_exec) begin
                    in_exec = 1'b1;
                    cyc     = 0;
                    didx    = n_disp;
                    n_disp++;
                end else begin
                    cyc++;
                end
                pcInc = (didx < 64) && (cyc == pinc_off[didx]);
                done  = (didx < 64) && (cyc == done_off[didx]);
            end else begin
                in_exec = 1'b0;
                pcInc   = noise_en && ($urandom_range(0, 1) == 1);
                done    = noise_en && ($urandom_range(0, 1) == 1);
            end
        end
    end

    initial begin : time_guard
        #2ms;
        $display("FAIL time_guard: simulation still running, got no finish, want finish");
        $fatal(1);
    end

    task automatic clear_setup(input logic [15:0] fill);
        for (int i = 0; i < 256; i++) prog[i] = fill;
        for (int i = 0; i < 64; i++) begin
            pinc_off[i] = -1;
            done_off[i] = -1;
        end
    endtask

    // Reset for one edge, then release with run=1; returns in cycle 0 (FETCH).
    task automatic start_run();
        rst = 1'b1;
        run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            rec_instr[c] = instruction;
            rec_pc[c]    = pc;
            rec_addr[c]  = pmem_addr;
            rec_halt[c]  = halted;
            rec_fault[c] = fault;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void set_exp(input int c, input logic [15:0] i, input int a,
                                    input bit h, input bit f);
        if (c >= 0 && c < MAXC) begin
            exp_instr[c] = i;
            exp_pc[c]    = 8'(a);
            exp_halt[c]  = h;
            exp_fault[c] = f;
        end
    endfunction

    // Timeline model: walk the program, 2 idle cycles per word, then the EXEC window.
    task automatic build_model(input int n);
        int t;
        int a;
        int d;
        int p;
        int q;
        int inc_at;
        int len;
        bit stop;
        logic [15:0] w;
        t = 0; a = 0; d = 0; stop = 1'b0;
        for (int c = 0; c < MAXC; c++) set_exp(c, 16'h0000, 0, 1'b0, 1'b0);
        while (t < n && !stop) begin
            w = prog[a];
            set_exp(t, 16'h0000, a, 1'b0, 1'b0);
            set_exp(t + 1, 16'h0000, a, 1'b0, 1'b0);
            t += 2;
            if (w[15:12] == 4'h0) begin
                a = (a + 1) % 256;
            end else if (w[15:12] == 4'hF) begin
                for (int c = t; c < n; c++) set_exp(c, 16'h0000, a, 1'b1, 1'b0);
                stop = 1'b1;
            end else begin
                p = (d < 64) ? pinc_off[d] : -1;
                q = (d < 64) ? done_off[d] : -1;
                d++;
                if (p < 0) inc_at = q;
                else if (q < 0) inc_at = p;
                else inc_at = (p < q) ? p : q;
                len = (q >= 0 && q < TIMEOUT) ? q + 1 : TIMEOUT;
                for (int k = 0; k < len; k++)
                    set_exp(t + k, w, (inc_at >= 0 && k > inc_at) ? (a + 1) % 256 : a,
                            1'b0, 1'b0);
                t += len;
                if (inc_at >= 0 && inc_at < len) a = (a + 1) % 256;
                if (!(q >= 0 && q < TIMEOUT)) begin
                    for (int c = t; c < n; c++) set_exp(c, 16'h0000, a, 1'b0, 1'b1);
                    stop = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        noise_en = 1'b1;
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pc !== 8'h00) begin
            errors++;
            $display("FAIL reset_pc: got %h want 00", pc);
        end
        checks++;
        if (instruction !== 16'h0000) begin
            errors++;
            $display("FAIL reset_instruction: got %h want 0000", instruction);
        end
        checks++;
        if ({halted, fault} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got halted=%b fault=%b want 0 0", halted, fault);
        end
        checks++;
        if (pmem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr: got %h want 00", pmem_addr);
        end
        // run=0: stays in FETCH, stray pcInc/done ignored
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({instruction, pc} !== 24'h0) begin
                errors++;
                $display("FAIL idle_no_run cycle %0d: got instr=%h pc=%h want 0000 00",
                         c, instruction, pc);
            end
        end
    endtask

    task automatic test_mov_halt();
        int n_on;
        clear_setup(16'hF000);
        prog[0] = 16'h5042;
        pinc_off[0] = 1;
        done_off[0] = 3;
        noise_en = 1'b1;
        start_run();
        run_cycles(12);
        build_model(12);
        n_on = 0;
        for (int c = 0; c < 12; c++) begin
            if (rec_instr[c] == 16'h5042) n_on++;
            checks++;
            if ({rec_instr[c], rec_pc[c], rec_addr[c], rec_halt[c], rec_fault[c]} !==
                {exp_instr[c], exp_pc[c], exp_pc[c], exp_halt[c], exp_fault[c]}) begin
                errors++;
                $display("FAIL mov_halt cycle %0d: got i=%h pc=%h a=%h h=%b f=%b want i=%h pc=%h h=%b f=%b",
                         c, rec_instr[c], rec_pc[c], rec_addr[c], rec_halt[c], rec_fault[c],
                         exp_instr[c], exp_pc[c], exp_halt[c], exp_fault[c]);
            end
        end
        checks++;
        if (n_on != 4) begin
            errors++;
            $display("FAIL mov_halt_width: got %0d cycles want 4", n_on);
        end
        checks++;
        if ({rec_instr[2], rec_halt[8], rec_pc[11]} !== {16'h5042, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL mov_halt_points: got i2=%h h8=%b pc=%h want 5042 1 01",
                     rec_instr[2], rec_halt[8], rec_pc[11]);
        end
    endtask

    task automatic test_back_to_back();
        int end0;
        int start1;
        clear_setup(16'hF000);
        prog[0] = 16'h5042;
        prog[1] = 16'h5042;
        pinc_off[0] = 1; done_off[0] = 3;
        pinc_off[1] = 1; done_off[1] = 3;
        noise_en = 1'b1;
        start_run();
        run_cycles(20);
        build_model(20);
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({rec_instr[c], rec_pc[c], rec_addr[c], rec_halt[c], rec_fault[c]} !==
                {exp_instr[c], exp_pc[c], exp_pc[c], exp_halt[c], exp_fault[c]}) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got i=%h pc=%h a=%h h=%b f=%b want i=%h pc=%h h=%b f=%b",
                         c, rec_instr[c], rec_pc[c], rec_addr[c], rec_halt[c], rec_fault[c],
                         exp_instr[c], exp_pc[c], exp_halt[c], exp_fault[c]);
            end
        end
        end0 = -1;
        start1 = -1;
        for (int c = 1; c < 20; c++) begin
            if (rec_instr[c - 1] != 16'h0 && rec_instr[c] == 16'h0 && end0 < 0) end0 = c;
            if (rec_instr[c - 1] == 16'h0 && rec_instr[c] != 16'h0 && end0 >= 0 && start1 < 0)
                start1 = c;
        end
        checks++;
        if (start1 - end0 != 2 || end0 < 0) begin
            errors++;
            $display("FAIL back_to_back_gap: got %0d zero cycles want 2", start1 - end0);
        end
        checks++;
        if ({rec_pc[19], rec_halt[19]} !== {8'h02, 1'b1}) begin
            errors++;
            $display("FAIL back_to_back_end: got pc=%h halted=%b want 02 1",
                     rec_pc[19], rec_halt[19]);
        end
    endtask

    task automatic test_nop_halt();
        int n_nz;
        clear_setup(16'hF000);
        prog[0] = 16'h0000;
        prog[1] = 16'hF000;
        noise_en = 1'b1;
        start_run();
        run_cycles(8);
        n_nz = 0;
        for (int c = 0; c < 8; c++) if (rec_instr[c] != 16'h0) n_nz++;
        checks++;
        if (n_nz != 0) begin
            errors++;
            $display("FAIL nop_halt_instr: got %0d nonzero cycles want 0", n_nz);
        end
        checks++;
        if ({rec_halt[3], rec_halt[4], rec_pc[7]} !== {1'b0, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL nop_halt_timing: got h3=%b h4=%b pc=%h want 0 1 01",
                     rec_halt[3], rec_halt[4], rec_pc[7]);
        end
    endtask

    task automatic test_timeout();
        clear_setup(16'hF000);
        prog[0] = 16'h5042;
        noise_en = 1'b0;
        start_run();
        run_cycles(30);
        build_model(30);
        for (int c = 0; c < 30; c++) begin
            checks++;
            if ({rec_instr[c], rec_pc[c], rec_halt[c], rec_fault[c]} !==
                {exp_instr[c], exp_pc[c], exp_halt[c], exp_fault[c]}) begin
                errors++;
                $display("FAIL timeout cycle %0d: got i=%h pc=%h h=%b f=%b want i=%h pc=%h h=%b f=%b",
                         c, rec_instr[c], rec_pc[c], rec_halt[c], rec_fault[c],
                         exp_instr[c], exp_pc[c], exp_halt[c], exp_fault[c]);
            end
        end
        checks++;
        if ({rec_fault[16], rec_fault[17], rec_instr[17], rec_pc[29]} !==
            {1'b0, 1'b1, 16'h0000, 8'h00}) begin
            errors++;
            $display("FAIL timeout_edge: got f16=%b f17=%b i17=%h pc=%h want 0 1 0000 00",
                     rec_fault[16], rec_fault[17], rec_instr[17], rec_pc[29]);
        end
    endtask

    task automatic test_pc_wrap();
        clear_setup(16'h0000);
        noise_en = 1'b1;
        start_run();
        run_cycles(516);
        build_model(516);
        for (int c = 0; c < 516; c++) begin
            checks++;
            if ({rec_instr[c], rec_pc[c], rec_addr[c]} !== {exp_instr[c], exp_pc[c], exp_pc[c]}) begin
                errors++;
                $display("FAIL pc_wrap cycle %0d: got i=%h pc=%h a=%h want i=%h pc=%h",
                         c, rec_instr[c], rec_pc[c], rec_addr[c], exp_instr[c], exp_pc[c]);
            end
        end
        checks++;
        if ({rec_pc[511], rec_pc[512], rec_addr[512]} !== {8'hFF, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL pc_wrap_edge: got pc511=%h pc512=%h addr512=%h want ff 00 00",
                     rec_pc[511], rec_pc[512], rec_addr[512]);
        end
    endtask

    task automatic test_inc_done_reset();
        clear_setup(16'hF000);
        prog[0] = 16'h5042; pinc_off[0] = 2;  done_off[0] = 2;
        prog[1] = 16'h5123; pinc_off[1] = -1; done_off[1] = 1;
        prog[2] = 16'h5777;
        noise_en = 1'b1;
        start_run();
        run_cycles(15);
        build_model(16);
        for (int c = 0; c < 15; c++) begin
            checks++;
            if ({rec_instr[c], rec_pc[c], rec_halt[c], rec_fault[c]} !==
                {exp_instr[c], exp_pc[c], exp_halt[c], exp_fault[c]}) begin
                errors++;
                $display("FAIL inc_done cycle %0d: got i=%h pc=%h h=%b f=%b want i=%h pc=%h h=%b f=%b",
                         c, rec_instr[c], rec_pc[c], rec_halt[c], rec_fault[c],
                         exp_instr[c], exp_pc[c], exp_halt[c], exp_fault[c]);
            end
        end
        checks++;
        if ({instruction, pc} !== {exp_instr[15], exp_pc[15]}) begin
            errors++;
            $display("FAIL mid_exec_before_rst: got i=%h pc=%h want i=%h pc=%h",
                     instruction, pc, exp_instr[15], exp_pc[15]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({instruction, pc, fault} !== {16'h0000, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL mid_exec_rst: got i=%h pc=%h f=%b want 0000 00 0",
                     instruction, pc, fault);
        end
        rst = 1'b0;
        run = 1'b0;
    endtask

    task automatic test_random();
        int len;
        int q;
        for (int it = 0; it < 8; it++) begin
            clear_setup(16'hF000);
            len = int'($urandom_range(4, 10));
            for (int a = 0; a < len; a++) begin
                if ($urandom_range(0, 9) < 3) prog[a] = {4'h0, 12'($urandom)};
                else prog[a] = {4'($urandom_range(1, 14)), 12'($urandom)};
            end
            prog[len] = {4'hF, 12'($urandom)};
            for (int d = 0; d < 64; d++) begin
                q = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 8));
                done_off[d] = q;
                pinc_off[d] = ($urandom_range(0, 1) == 1) ? -1 :
                              int'($urandom_range(0, (q < 0) ? 6 : q + 1));
            end
            noise_en = 1'b1;
            start_run();
            run_cycles(260);
            build_model(260);
            for (int c = 0; c < 260; c++) begin
                checks++;
                if ({rec_instr[c], rec_pc[c], rec_addr[c], rec_halt[c], rec_fault[c]} !==
                    {exp_instr[c], exp_pc[c], exp_pc[c], exp_halt[c], exp_fault[c]}) begin
                    errors++;
                    $display("FAIL random[%0d] cycle %0d: got i=%h pc=%h a=%h h=%b f=%b want i=%h pc=%h h=%b f=%b",
                             it, c, rec_instr[c], rec_pc[c], rec_addr[c], rec_halt[c],
                             rec_fault[c], exp_instr[c], exp_pc[c], exp_halt[c], exp_fault[c]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
        for (int i = 0; i < 64; i++) begin
            pinc_off[i] = -1;
            done_off[i] = -1;
        end
        test_reset();
        test_mov_halt();
        test_back_to_back();
        test_nop_halt();
        test_timeout();
        test_pc_wrap();
        test_inc_done_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/dispatch controller that drives execution FSMs through the shared `instruction` / `pcInc` / `done` interface.
- Owns the program counter and reads program memory.
- Presents one instruction at a time to the execution FSMs (MOV, etc.) and waits for their completion handshake.
- Forces an all-zero instruction between dispatches so every execution FSM returns to its idle state.

Parameters:
- PC_W, 8, program-counter / program-memory address width
- INSTR_W, 16, instruction width; opcode is [INSTR_W-1:INSTR_W-4]
- TIMEOUT, 15, max EXEC cycles without `done` before fault

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; permits fetching new instructions
- pmem_addr  out  PC_W  program-memory read address; combinational = pc
- pmem_data  in  INSTR_W  program-memory read data; valid one cycle after address (synchronous RAM)
- instruction  out  INSTR_W  instruction to execution FSMs; 0 outside EXEC
- pcInc  in  1  execution FSM request to advance pc
- done  in  1  execution FSM completion pulse
- pc  out  PC_W  current program counter
- halted  out  1  HALT opcode reached; sticky
- fault  out  1  execution timeout; sticky

Behaviour:
- Reset (sync, rst=1 at clk edge): state=FETCH, pc=0, ir=0, instruction=0, halted=0, fault=0, watchdog=0. rst overrides everything, including mid-EXEC.
- States: FETCH, LOAD, EXEC, HALT, FAULT.
- FETCH:
  - pmem_addr=pc.
  - run=1 -> LOAD.
  - run=0 -> stay in FETCH.
- LOAD:
  - ir <= pmem_data.
  - Opcode 4'b0000 (NOP): pc <= pc+1, -> FETCH; no dispatch.
  - Opcode 4'b1111 (HALT): -> HALT; pc unchanged.
  - Otherwise: -> EXEC, watchdog cleared.
- EXEC:
  - instruction=ir; watchdog increments each cycle.
  - pcInc=1 and no increment yet this instruction: pc <= pc+1, set inc_seen. Further pcInc pulses in the same instruction are ignored.
  - done=1: if inc_seen=0, pc <= pc+1 (auto-advance). -> FETCH, clear inc_seen.
  - pcInc and done in the same cycle: exactly one increment.
  - run deasserted during EXEC is ignored until done.
  - watchdog reaches TIMEOUT with done=0: -> FAULT. done on the same cycle as TIMEOUT wins.
- HALT: halted=1, instruction=0; exit only by rst.
- FAULT: fault=1, instruction=0; pc frozen; exit only by rst.
- pc arithmetic: unsigned, wraps 2^PC_W-1 -> 0 silently.
- Latency:
  - rst release with run=1: FETCH (cycle 0), LOAD (cycle 1), instruction valid from cycle 2.
  - instruction=0 for at least 2 cycles (FETCH, LOAD) between consecutive dispatches, so back-to-back identical opcodes restart the execution FSM.
- pcInc/done outside EXEC are ignored.

Optional Feature:
- Macro: SEQ_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit).
  - FETCH advances to LOAD only when run=1 and step=1 in the same cycle, giving one instruction per step pulse.
  - A step held high across FETCH issues only one fetch; a rising edge is required for the next.
- Undefined: no `step` port; free-running while run=1.

Decomposition:
- Package `isa_pkg`:
  - Opcode constants OP_NOP=4'b0000, OP_MOV=4'b0101, OP_HALT=4'b1111.
  - Opcode field position.
  - Sequencer state encoding (3-bit constants).
  - Shared by this block and all execution FSMs.
- Sub-module `seq_watchdog`:
  - Clearable up-counter with TIMEOUT compare.
  - Inputs: clk, rst, clr, en. Output: expired.

Test Plan:
1. Memory {0x5042 MOV, 0xF000}, FSM model pulses pcInc at EXEC+1 and done at EXEC+3 -> instruction=0x5042 for 4 cycles, then 0 in FETCH/LOAD; pc 0->1; halted=1 with pc=1.
2. Two consecutive 0x5042 words -> instruction drops to 0 for exactly 2 cycles between dispatches; pc ends at 2 before HALT.
3. NOP at addr 0, HALT at addr 1 -> instruction never nonzero; pc=1; halted=1 by cycle 4.
4. Model never asserts done, TIMEOUT=15 -> fault=1 on EXEC entry +15 cycles; pc unchanged; instruction=0 thereafter.
5. pc preloaded to 0xFF via memory of NOPs (run 256 NOPs) -> pc wraps to 0x00; next fetch addr 0.
6. pcInc+done same cycle, then done without pcInc, then rst asserted mid-EXEC -> each instruction advances pc by exactly 1; rst forces pc=0, instruction=0 on the next edge.
